// File: rtl/matrix_cps_pkg.sv
// rtl/matrix_cps_pkg.sv - shared types for the systolic-array dispatch scoreboard
package matrix_cps_pkg;

    localparam int SA_N_MREGS = 8;
    localparam int MREG_IDX_W = $clog2(SA_N_MREGS);

    typedef struct packed {
        logic [MREG_IDX_W-1:0] rd;
        logic [MREG_IDX_W-1:0] rs1;
        logic [MREG_IDX_W-1:0] rs2;
    } sa_instr_t;

    typedef struct packed {
        logic                  valid;
        logic                  rd_pend;
        logic [MREG_IDX_W-1:0] rd;
        logic [MREG_IDX_W-1:0] rs1;
        logic [MREG_IDX_W-1:0] rs2;
    } sb_entry_t;

endpackage

// File: rtl/sa_dispatch_scoreboard_if.sv
// rtl/sa_dispatch_scoreboard_if.sv - instruction, issue-queue and completion handshake bundle
interface sa_dispatch_scoreboard_if;
    import matrix_cps_pkg::*;

    logic      instr_valid_i;
    sa_instr_t instr_i;
    logic      instr_ready_o;
    logic      issue_queue_full_i;
    logic      dispatch_o;
    sa_instr_t dispatched_instr_o;
    logic      sa_read_done_i;
    logic      sa_retire_i;

    modport master (
        output instr_valid_i, instr_i, issue_queue_full_i, sa_read_done_i, sa_retire_i,
        input  instr_ready_o, dispatch_o, dispatched_instr_o
    );

    modport slave (
        input  instr_valid_i, instr_i, issue_queue_full_i, sa_read_done_i, sa_retire_i,
        output instr_ready_o, dispatch_o, dispatched_instr_o
    );
endinterface

// File: rtl/sa_hazard_check.sv
// rtl/sa_hazard_check.sv - combinational RAW/WAW/WAR compare of one instruction against the table
module sa_hazard_check
    import matrix_cps_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sa_instr_t instr_i,
    input  sb_entry_t table_i [DEPTH],
    output logic      raw_o,
    output logic      war_o
);

    // The rd==rd term doubles as the WAW check: the accumulator is also read.
    always_comb begin
        raw_o = 1'b0;
        war_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (table_i[i].valid) begin
                if (table_i[i].rd == instr_i.rs1 || table_i[i].rd == instr_i.rs2 ||
                    table_i[i].rd == instr_i.rd)
                    raw_o = 1'b1;
                if (table_i[i].rd_pend &&
                    (instr_i.rd == table_i[i].rs1 || instr_i.rd == table_i[i].rs2))
                    war_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_dispatch_scoreboard.sv
// rtl/sa_dispatch_scoreboard.sv - in-order hazard scoreboard gating dispatch into the issue queue
module sa_dispatch_scoreboard
    import matrix_cps_pkg::*;
#(
    parameter int N_MREGS      = SA_N_MREGS,
    parameter int MAX_INFLIGHT = 4,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1),
    localparam int PTR_W       = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    sa_dispatch_scoreboard_if.slave  sb_if,
    output logic [CNT_W-1:0]         inflight_cnt_o,
    output logic                     idle_o
);

    if (N_MREGS != SA_N_MREGS) begin : g_mreg_mismatch
        $error("N_MREGS must match the register index width of sa_instr_t");
    end

    sb_entry_t        table_q [MAX_INFLIGHT];
    logic [PTR_W-1:0] alloc_ptr_q, read_ptr_q, ret_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idle_q;
    logic             raw, war, any_pend, table_full, dispatch, read_ok, ret_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    sa_hazard_check #(.DEPTH(MAX_INFLIGHT)) u_hazard (
        .instr_i (sb_if.instr_i),
        .table_i (table_q),
        .raw_o   (raw),
        .war_o   (war)
    );

    always_comb begin
        any_pend = 1'b0;
        for (int i = 0; i < MAX_INFLIGHT; i++)
            if (table_q[i].valid && table_q[i].rd_pend) any_pend = 1'b1;
    end

    // Full is judged on the registered count, so a same-cycle retire never frees a slot.
    assign table_full = (cnt_q == CNT_W'(MAX_INFLIGHT));
    assign dispatch   = sb_if.instr_valid_i & ~raw & ~war & ~sb_if.issue_queue_full_i & ~table_full;
    assign read_ok    = sb_if.sa_read_done_i & any_pend;
    assign ret_ok     = sb_if.sa_retire_i & (cnt_q != '0);
    assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, dispatch} - {{(CNT_W-1){1'b0}}, ret_ok};

    assign sb_if.dispatch_o         = dispatch;
    assign sb_if.instr_ready_o      = dispatch;
    assign sb_if.dispatched_instr_o = sb_if.instr_i;
    assign inflight_cnt_o           = cnt_q;
    assign idle_o                   = idle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) table_q[i] <= '0;
            alloc_ptr_q <= '0;
            read_ptr_q  <= '0;
            ret_ptr_q   <= '0;
            cnt_q       <= '0;
            idle_q      <= 1'b1;
        end else begin
            if (dispatch) begin
                table_q[alloc_ptr_q] <= '{valid: 1'b1, rd_pend: 1'b1, rd: sb_if.instr_i.rd,
                                          rs1: sb_if.instr_i.rs1, rs2: sb_if.instr_i.rs2};
                alloc_ptr_q <= ptr_inc(alloc_ptr_q);
            end
            if (read_ok) begin
                table_q[read_ptr_q].rd_pend <= 1'b0;
                read_ptr_q <= ptr_inc(read_ptr_q);
            end
            if (ret_ok) begin
                table_q[ret_ptr_q].valid <= 1'b0;
                ret_ptr_q <= ptr_inc(ret_ptr_q);
            end
            cnt_q  <= cnt_d;
            idle_q <= (cnt_d == '0);
        end
    end

    a_read_done_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sb_if.sa_read_done_i |-> any_pend);
    a_retire_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sb_if.sa_retire_i |-> (cnt_q != '0));
    a_retire_after_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ret_ok |-> (!table_q[ret_ptr_q].rd_pend || (read_ok && read_ptr_q == ret_ptr_q)));

endmodule

// File: tb/tb_sa_dispatch_scoreboard.sv
// tb/tb_sa_dispatch_scoreboard.sv - directed self-checking bench for sa_dispatch_scoreboard
module tb_sa_dispatch_scoreboard;
    import matrix_cps_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cnt;
    logic       idle;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    sa_dispatch_scoreboard_if sb_if ();

    sa_dispatch_scoreboard dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sb_if          (sb_if),
        .inflight_cnt_o (cnt),
        .idle_o         (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic sa_instr_t mk(input int rd, input int rs1, input int rs2);
        sa_instr_t r;
        r.rd  = MREG_IDX_W'(rd);
        r.rs1 = MREG_IDX_W'(rs1);
        r.rs2 = MREG_IDX_W'(rs2);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic rdone, input logic ret);
        sb_if.sa_read_done_i = rdone;
        sb_if.sa_retire_i    = ret;
        step();
        sb_if.sa_read_done_i = 1'b0;
        sb_if.sa_retire_i    = 1'b0;
    endtask

    initial begin
        sb_if.instr_valid_i      = 1'b0;
        sb_if.instr_i            = mk(0, 0, 0);
        sb_if.issue_queue_full_i = 1'b0;
        sb_if.sa_read_done_i     = 1'b0;
        sb_if.sa_retire_i        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_cnt", cnt, 0);
        chk("reset_idle", idle, 1);
        chk("reset_dispatch", sb_if.dispatch_o, 0);
        chk("reset_ready", sb_if.instr_ready_o, 0);

        // independent stream
        sb_if.instr_valid_i = 1'b1;
        sb_if.instr_i = mk(0, 1, 2);
        #1;
        chk("indep0_dispatch", sb_if.dispatch_o, 1);
        chk("indep0_ready", sb_if.instr_ready_o, 1);
        chk("indep0_passthru", sb_if.dispatched_instr_o, mk(0, 1, 2));
        step();
        chk("indep_cnt1", cnt, 1);
        sb_if.instr_i = mk(3, 4, 5);
        #1;
        chk("indep1_dispatch", sb_if.dispatch_o, 1);
        step();
        sb_if.instr_valid_i = 1'b0;
        chk("indep_cnt2", cnt, 2);
        chk("indep_idle", idle, 0);
        pulse(1, 0);
        pulse(1, 1);
        pulse(0, 1);
        chk("drain1_idle", idle, 1);
        chk("drain1_cnt", cnt, 0);

        // RAW: rd=2 in flight, consumer reads 2
        sb_if.instr_valid_i = 1'b1;
        sb_if.instr_i = mk(2, 0, 1);
        #1;
        chk("raw_prod_dispatch", sb_if.dispatch_o, 1);
        step();
        sb_if.instr_i = mk(4, 2, 3);
        #1;
        chk("raw_block_dispatch", sb_if.dispatch_o, 0);
        chk("raw_block_ready", sb_if.instr_ready_o, 0);
        sb_if.sa_read_done_i = 1'b1;
        #1;
        chk("raw_readdone_cycle", sb_if.dispatch_o, 0);
        step();
        sb_if.sa_read_done_i = 1'b0;
        sb_if.sa_retire_i = 1'b1;
        #1;
        chk("raw_retire_cycle_T", sb_if.dispatch_o, 0);
        step();
        sb_if.sa_retire_i = 1'b0;
        #1;
        chk("raw_dispatch_T1", sb_if.dispatch_o, 1);
        chk("raw_idle_after_retire", idle, 1);
        step();
        sb_if.instr_valid_i = 1'b0;
        chk("raw_cnt_after", cnt, 1);
        pulse(1, 0);
        pulse(0, 1);

        // WAR: rs1=6 pending read, new rd=6
        sb_if.instr_valid_i = 1'b1;
        sb_if.instr_i = mk(7, 6, 0);
        #1;
        chk("war_first_dispatch", sb_if.dispatch_o, 1);
        step();
        sb_if.instr_i = mk(6, 1, 2);
        #1;
        chk("war_block", sb_if.dispatch_o, 0);
        sb_if.sa_read_done_i = 1'b1;
        #1;
        chk("war_readdone_cycle", sb_if.dispatch_o, 0);
        step();
        sb_if.sa_read_done_i = 1'b0;
        #1;
        chk("war_dispatch_after_read", sb_if.dispatch_o, 1);
        chk("war_cnt_before_retire", cnt, 1);
        step();
        sb_if.instr_valid_i = 1'b0;
        chk("war_cnt2", cnt, 2);
        pulse(1, 1);
        pulse(0, 1);
        chk("drain2_idle", idle, 1);

        // Full table
        for (int i = 0; i < 4; i++) begin
            sb_if.instr_valid_i = 1'b1;
            sb_if.instr_i = mk(i, 4, 5);
            #1;
            chk($sformatf("full_fill%0d", i), sb_if.dispatch_o, 1);
            step();
        end
        sb_if.instr_valid_i = 1'b0;
        chk("full_cnt4", cnt, 4);
        pulse(1, 0);
        sb_if.instr_valid_i = 1'b1;
        sb_if.instr_i = mk(6, 7, 7);
        sb_if.sa_retire_i = 1'b1;
        #1;
        chk("full_retire_same_cycle", sb_if.dispatch_o, 0);
        step();
        sb_if.sa_retire_i = 1'b0;
        #1;
        chk("full_cnt3", cnt, 3);
        chk("full_dispatch_next", sb_if.dispatch_o, 1);
        step();
        sb_if.instr_valid_i = 1'b0;
        chk("full_cnt4_again", cnt, 4);

        // Backpressure from the issue queue
        pulse(1, 0);
        pulse(0, 1);
        sb_if.instr_valid_i = 1'b1;
        sb_if.instr_i = mk(0, 0, 1);
        sb_if.issue_queue_full_i = 1'b1;
        #1;
        chk("bp_block", sb_if.dispatch_o, 0);
        step();
        chk("bp_cnt_unchanged", cnt, 3);
        sb_if.issue_queue_full_i = 1'b0;
        #1;
        chk("bp_release_dispatch", sb_if.dispatch_o, 1);
        step();
        sb_if.instr_valid_i = 1'b0;
        chk("bp_cnt4", cnt, 4);

        // Asynchronous reset with 3 in flight
        pulse(1, 0);
        pulse(0, 1);
        chk("rst_pre_cnt3", cnt, 3);
        sb_if.instr_valid_i = 1'b1;
        sb_if.instr_i = mk(1, 2, 3);
        #1;
        chk("rst_pre_hazard", sb_if.dispatch_o, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_idle", idle, 1);
        chk("rst_async_cnt", cnt, 0);
        chk("rst_async_dispatch", sb_if.dispatch_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_dispatch", sb_if.dispatch_o, 1);
        step();
        sb_if.instr_valid_i = 1'b0;
        chk("rst_post_cnt", cnt, 1);
        chk("rst_post_idle", idle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
